crc_stream_engine: RTL and testbench

Parametrised, multi-cycle CRC engine for the CAN controller. It computes any MSB-first CRC of width CRC_W over a frame delivered as a stream of DATA_W-bit words, each carrying a variable bit count. It processes BPC bits per clock and gives valid/ready handshakes on both input and result. It also supports an optional check mode that compares the result against a received CRC, and it is the successor to the fixed 32-bit-data/CRC-16 single-cycle generator.

---
 rtl/crc_stream_engine.sv | 83 ++++++++
 tb/tb_crc_stream_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: multi-cycle MSB-first CRC over a stream of variable-length words, BPC bits per clock.
module crc_stream_engine #(
  parameter int CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY = 15'h4599,
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int DATA_W = 32,
  parameter int BPC = 8,
  localparam int NW = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NW-1:0]     in_nbits,
  input  logic              in_last,
  input  logic [CRC_W-1:0]  chk_crc,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nxt;
  logic [CRC_W-1:0] crc_q, chk_q, c;
  logic [DATA_W-1:0] data_q;
  logic [NW-1:0] rem, n, nb;
  logic last_q, active, fb, accept;
  always_comb begin
    c = crc_q;
    fb = 1'b0;
    for (int i = 0; i < BPC; i++)
      if (i < int'(rem)) begin
        fb = data_q[DATA_W-1-i] ^ c[CRC_W-1];
        c = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
  end
  assign n = rem < NW'(BPC) ? rem : NW'(BPC);
  assign nb = (in_nbits == '0 || in_nbits > NW'(DATA_W)) ? NW'(DATA_W) : in_nbits;
  always_comb begin
    in_ready = state == IDLE;
    accept = in_valid && in_ready && !abort;
    nxt = abort ? IDLE :
          state == IDLE ? (accept ? BUSY : IDLE) :
          state == BUSY ? (rem == n ? (last_q ? DONE : IDLE) : BUSY) :
          (crc_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // A non-last word keeps the running CRC; only a frame's first word reloads INIT.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      crc_q <= INIT;
      chk_q <= '0;
      data_q <= '0;
      rem <= '0;
      last_q <= 1'b0;
      active <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (accept) begin
      data_q <= in_data;
      rem <= nb;
      last_q <= in_last;
      if (in_last) chk_q <= chk_crc;
      if (!active) begin
        crc_q <= INIT;
        active <= 1'b1;
      end
    end else if (state == BUSY) begin
      crc_q <= c;
      data_q <= data_q << n;
      rem <= rem - n;
    end else if (state == DONE && crc_ready) begin
      active <= 1'b0;
    end
  assign crc_valid = state == DONE;
  assign crc_out = crc_q ^ XOR_OUT;
  assign crc_ok = crc_valid && crc_out == chk_q;
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: directed checks of a CAN CRC-15 engine and a CRC-16/CCITT-FALSE engine.
module tb_crc_stream_engine;
  logic clk = 0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;

  logic a_rst_n, a_abort, a_valid, a_ready, a_last, a_cvalid, a_cready, a_ok;
  logic [31:0] a_data;
  logic [5:0] a_nbits;
  logic [14:0] a_chk, a_out;
  logic b_rst_n, b_abort, b_valid, b_ready, b_last, b_cvalid, b_cready, b_ok;
  logic [31:0] b_data;
  logic [5:0] b_nbits;
  logic [15:0] b_chk, b_out;

  crc_stream_engine u_a (
    .clk(clk), .rst_n(a_rst_n), .abort(a_abort), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_nbits(a_nbits), .in_last(a_last), .chk_crc(a_chk),
    .crc_valid(a_cvalid), .crc_ready(a_cready), .crc_out(a_out), .crc_ok(a_ok));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)) u_b (
    .clk(clk), .rst_n(b_rst_n), .abort(b_abort), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_nbits(b_nbits), .in_last(b_last), .chk_crc(b_chk),
    .crc_valid(b_cvalid), .crc_ready(b_cready), .crc_out(b_out), .crc_ok(b_ok));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [31:0] d, input logic [5:0] nb, input logic l, input logic [14:0] ck);
    int t = 0;
    while (!a_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check("a_rdy_timeout", 0, 1);
    a_valid = 1; a_data = d; a_nbits = nb; a_last = l; a_chk = ck;
    @(posedge clk); #1;
    a_valid = 0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic [5:0] nb, input logic l, input logic [15:0] ck);
    int t = 0;
    while (!b_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check("b_rdy_timeout", 0, 1);
    b_valid = 1; b_data = d; b_nbits = nb; b_last = l; b_chk = ck;
    @(posedge clk); #1;
    b_valid = 0;
  endtask

  task automatic wait_a;
    int t = 0;
    while (!a_cvalid && t < 100) begin @(posedge clk); #1; t++; end
    check("a_valid_wait", a_cvalid, 1);
  endtask

  task automatic wait_b;
    int t = 0;
    while (!b_cvalid && t < 100) begin @(posedge clk); #1; t++; end
    check("b_valid_wait", b_cvalid, 1);
  endtask

  task automatic pop_a;
    a_cready = 1;
    @(posedge clk); #1;
    a_cready = 0;
    check("a_pop_valid", a_cvalid, 0);
    check("a_pop_ready", a_ready, 1);
  endtask

  initial begin
    a_rst_n = 0; a_abort = 0; a_valid = 0; a_data = 0; a_nbits = 0; a_last = 0; a_chk = 0; a_cready = 0;
    b_rst_n = 0; b_abort = 0; b_valid = 0; b_data = 0; b_nbits = 0; b_last = 0; b_chk = 0; b_cready = 0;
    repeat (2) @(posedge clk);
    #1 a_rst_n = 1; b_rst_n = 1;
    @(posedge clk); #1;
    check("rst_ready", a_ready, 1);
    check("rst_valid", a_cvalid, 0);
    check("rst_out", a_out, 0);
    check("rst_ok", a_ok, 0);
    check("rst_b_out", b_out, 16'hFFFF);

    send_a(32'h8000_0000, 1, 1, 0);
    check("one_lat0", a_cvalid, 0);
    check("one_busy_rdy", a_ready, 0);
    @(posedge clk); #1;
    check("one_lat1", a_cvalid, 1);
    check("one_out", a_out, 15'h4599);
    check("one_ok", a_ok, 0);
    check("done_rdy", a_ready, 0);
    pop_a();

    send_a(32'h8000_0000, 2, 1, 15'h4EAB);
    wait_a();
    check("two_out", a_out, 15'h4EAB);
    check("two_ok", a_ok, 1);
    pop_a();
    check("ok_forced0", a_ok, 0);

    send_a(32'h8000_0000, 1, 0, 0);
    send_a(32'h0000_0000, 1, 1, 15'h4EAA);
    wait_a();
    check("split_out", a_out, 15'h4EAB);
    check("split_ok", a_ok, 0);
    pop_a();

    // 31 zeros then a 1: only correct if nbits=0 is taken as 32
    send_a(32'h0000_0001, 0, 1, 15'h4599);
    repeat (3) @(posedge clk);
    #1 check("clamp0_lat3", a_cvalid, 0);
    @(posedge clk); #1;
    check("clamp0_lat4", a_cvalid, 1);
    check("clamp0_out", a_out, 15'h4599);
    check("clamp0_ok", a_ok, 1);
    pop_a();
    send_a(32'h0000_0001, 40, 1, 0);
    wait_a();
    check("clamp40_out", a_out, 15'h4599);
    pop_a();

    send_a(32'hFFFF_FFFF, 32, 0, 0);
    @(posedge clk); #1;
    a_abort = 1; a_valid = 1; a_data = 32'h8000_0000; a_nbits = 1; a_last = 1;
    @(posedge clk); #1;
    a_abort = 0; a_valid = 0;
    check("abort_ready", a_ready, 1);
    check("abort_valid", a_cvalid, 0);
    send_a(32'h8000_0000, 1, 1, 0);
    wait_a();
    check("abort_reinit", a_out, 15'h4599);

    @(negedge clk) a_rst_n = 0;
    #1;
    check("rst_done_valid", a_cvalid, 0);
    check("rst_done_out", a_out, 0);
    check("rst_done_ready", a_ready, 0 == 1 ? 0 : a_rst_n ? 1 : a_ready);
    @(posedge clk); #1 a_rst_n = 1;

    send_b(32'h3132_3334, 32, 0, 0);
    send_b(32'h3536_3738, 32, 0, 0);
    send_b(32'h3900_0000, 8, 1, 16'h29B1);
    wait_b();
    for (int k = 0; k < 5; k++) begin
      check("b_hold_valid", b_cvalid, 1);
      check("b_hold_out", b_out, 16'h29B1);
      check("b_hold_ok", b_ok, 1);
      check("b_hold_rdy", b_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk) b_rst_n = 0;
    #1;
    check("b_rst_valid", b_cvalid, 0);
    check("b_rst_out", b_out, 16'hFFFF);
    check("b_rst_ok", b_ok, 0);
    @(posedge clk); #1 b_rst_n = 1;
    @(posedge clk); #1;
    check("b_rst_ready", b_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
